// File: rtl/wbarbiter.sv
// Two-requester Wishbone arbiter: round-robin grant of one shared downstream
// port, combinational muxing and a forced completion when the slave never acks.
module wbarbiter #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_we_i,
  input  logic [15:0] m0_wb_adr_i,
  input  logic [7:0]  m0_wb_dat_i,
  output logic [7:0]  m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_we_i,
  input  logic [15:0] m1_wb_adr_i,
  input  logic [7:0]  m1_wb_dat_i,
  output logic [7:0]  m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_we_o,
  output logic [15:0] s_wb_adr_o,
  output logic [7:0]  s_wb_dat_o,
  input  logic [7:0]  s_wb_dat_i,
  input  logic        s_wb_ack_i,
  output logic [1:0]  gnt,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  // Handshake: a transfer is offered while stb (inside cyc) is high and
  // completes in the cycle ack is high; stb is held until that ack.
  logic [1:0]       state_q, state_d;
  logic             rr_q;          // 1: requester 1 wins the next tie
  logic [CNT_W-1:0] cnt_q;

  logic        own_stb, own_cyc, own_we;
  logic [15:0] own_adr;
  logic [7:0]  own_dat;
  logic        timeout_hit;
  logic        own_ack;
  logic [7:0]  own_rdat;

  always_comb begin
    own_stb = 1'b0;
    own_cyc = 1'b0;
    own_we  = 1'b0;
    own_adr = 16'h0000;
    own_dat = 8'h00;
    case (state_q)
      OWN0: begin
        own_stb = m0_wb_stb_i;
        own_cyc = m0_wb_cyc_i;
        own_we  = m0_wb_we_i;
        own_adr = m0_wb_adr_i;
        own_dat = m0_wb_dat_i;
      end
      OWN1: begin
        own_stb = m1_wb_stb_i;
        own_cyc = m1_wb_cyc_i;
        own_we  = m1_wb_we_i;
        own_adr = m1_wb_adr_i;
        own_dat = m1_wb_dat_i;
      end
      default: ;
    endcase
  end

  // A real ack in the expiry cycle wins, so expiry requires no ack.
  assign timeout_hit = own_stb && !s_wb_ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign own_ack     = s_wb_ack_i || timeout_hit;
  assign own_rdat    = timeout_hit ? 8'hFF : s_wb_dat_i;

  assign s_wb_stb_o = own_stb && !timeout_hit;
  assign s_wb_cyc_o = own_cyc;
  assign s_wb_we_o  = own_we;
  assign s_wb_adr_o = own_adr;
  assign s_wb_dat_o = own_dat;

  assign m0_wb_ack_o = (state_q == OWN0) && own_ack;
  assign m0_wb_dat_o = (state_q == OWN0) ? own_rdat : 8'h00;
  assign m1_wb_ack_o = (state_q == OWN1) && own_ack;
  assign m1_wb_dat_o = (state_q == OWN1) ? own_rdat : 8'h00;

  assign gnt       = {state_q == OWN1, state_q == OWN0};
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) state_d = rr_q ? OWN1 : OWN0;
        else if (m0_wb_cyc_i)           state_d = OWN0;
        else if (m1_wb_cyc_i)           state_d = OWN1;
      end
      OWN0:    if (!m0_wb_cyc_i) state_d = IDLE;
      OWN1:    if (!m1_wb_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == OWN0) rr_q <= 1'b1;
      if (state_q == IDLE && state_d == OWN1) rr_q <= 1'b0;
      if (!own_stb || s_wb_ack_i || timeout_hit) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + CNT_W'(1);
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wbarbiter.sv
// Directed bench for wbarbiter with TIMEOUT=8: arbitration, muxing,
// timeout completion, error flag and mid-transfer reset.
module tb_wbarbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_wb_stb_i, m0_wb_cyc_i, m0_wb_we_i;
  logic [15:0] m0_wb_adr_i;
  logic [7:0]  m0_wb_dat_i, m0_wb_dat_o;
  logic        m0_wb_ack_o;
  logic        m1_wb_stb_i, m1_wb_cyc_i, m1_wb_we_i;
  logic [15:0] m1_wb_adr_i;
  logic [7:0]  m1_wb_dat_i, m1_wb_dat_o;
  logic        m1_wb_ack_o;
  logic        s_wb_stb_o, s_wb_cyc_o, s_wb_we_o;
  logic [15:0] s_wb_adr_o;
  logic [7:0]  s_wb_dat_o, s_wb_dat_i;
  logic        s_wb_ack_i;
  logic [1:0]  gnt;
  logic        timeout_err;
  logic        err_clr;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wbarbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_we_i(m0_wb_we_i),
    .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i),
    .m0_wb_dat_o(m0_wb_dat_o), .m0_wb_ack_o(m0_wb_ack_o),
    .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_we_i(m1_wb_we_i),
    .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i),
    .m1_wb_dat_o(m1_wb_dat_o), .m1_wb_ack_o(m1_wb_ack_o),
    .s_wb_stb_o(s_wb_stb_o), .s_wb_cyc_o(s_wb_cyc_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i),
    .gnt(gnt), .timeout_err(timeout_err), .err_clr(err_clr), .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_wb_stb_i = 0; m0_wb_cyc_i = 0; m0_wb_we_i = 0; m0_wb_adr_i = '0; m0_wb_dat_i = '0;
    m1_wb_stb_i = 0; m1_wb_cyc_i = 0; m1_wb_we_i = 0; m1_wb_adr_i = '0; m1_wb_dat_i = '0;
    s_wb_dat_i = '0; s_wb_ack_i = 0; err_clr = 0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);
    chk("rst_stb", 32'(s_wb_stb_o), 32'h0);
    chk("rst_state", 32'(fsm_state), 32'h0);
    step(); step();
    rst_n = 1'b1;

    // Round robin from reset
    m0_wb_cyc_i = 1; m1_wb_cyc_i = 1;
    settle();
    chk("rr_wait", 32'(gnt), 32'h0);
    step(); chk("rr_first_m0", 32'(gnt), 32'h1);
    step(); chk("rr_hold_m0", 32'(gnt), 32'h1);
    m0_wb_cyc_i = 0;
    step(); chk("rr_idle_gap", 32'(gnt), 32'h0);
    step(); chk("rr_then_m1", 32'(gnt), 32'h2);
    m0_wb_cyc_i = 1;
    step(); chk("rr_hold_m1", 32'(gnt), 32'h2);
    m1_wb_cyc_i = 0;
    step(); chk("rr_idle_gap2", 32'(gnt), 32'h0);
    m1_wb_cyc_i = 1;
    step(); chk("rr_back_m0", 32'(gnt), 32'h1);
    m0_wb_cyc_i = 0; m1_wb_cyc_i = 0;
    step(); step();
    chk("rr_end_idle", 32'(gnt), 32'h0);

    // Ack while idle is ignored
    s_wb_ack_i = 1; s_wb_dat_i = 8'h77;
    settle();
    chk("idle_ack_m0", 32'(m0_wb_ack_o), 32'h0);
    chk("idle_ack_m1", 32'(m1_wb_ack_o), 32'h0);
    chk("idle_dat_m0", 32'(m0_wb_dat_o), 32'h0);
    s_wb_ack_i = 0; s_wb_dat_i = 0;

    // m0 read of 0x0105, slave acks on the third stb cycle
    step();
    m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_we_i = 0; m0_wb_adr_i = 16'h0105;
    settle();
    chk("rd_pre_stb", 32'(s_wb_stb_o), 32'h0);
    step();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_stb", 32'(s_wb_stb_o), 32'h1);
    chk("rd_adr", 32'(s_wb_adr_o), 32'h0105);
    chk("rd_we", 32'(s_wb_we_o), 32'h0);
    step(); step();
    chk("rd_no_ack_yet", 32'(m0_wb_ack_o), 32'h0);
    s_wb_ack_i = 1; s_wb_dat_i = 8'h5A;
    settle();
    chk("rd_ack_m0", 32'(m0_wb_ack_o), 32'h1);
    chk("rd_dat_m0", 32'(m0_wb_dat_o), 32'h5A);
    chk("rd_ack_m1", 32'(m1_wb_ack_o), 32'h0);
    chk("rd_dat_m1", 32'(m1_wb_dat_o), 32'h0);
    step();
    s_wb_ack_i = 0; s_wb_dat_i = 0;
    m0_wb_cyc_i = 0; m0_wb_stb_i = 0;
    step();
    chk("rd_release", 32'(gnt), 32'h0);

    // m1 write 0xC3 to 0x0210
    m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_we_i = 1;
    m1_wb_adr_i = 16'h0210; m1_wb_dat_i = 8'hC3;
    step();
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_we", 32'(s_wb_we_o), 32'h1);
    chk("wr_adr", 32'(s_wb_adr_o), 32'h0210);
    chk("wr_dat", 32'(s_wb_dat_o), 32'hC3);
    chk("wr_cyc", 32'(s_wb_cyc_o), 32'h1);
    s_wb_ack_i = 1;
    settle();
    chk("wr_ack_m1", 32'(m1_wb_ack_o), 32'h1);
    chk("wr_ack_m0", 32'(m0_wb_ack_o), 32'h0);
    chk("wr_dat_m0", 32'(m0_wb_dat_o), 32'h0);
    step();
    s_wb_ack_i = 0;
    m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0;
    step();
    chk("wr_release", 32'(gnt), 32'h0);

    // Timeout on m0: forced ack on the 8th stb cycle
    m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_adr_i = 16'h0300;
    step();
    for (int i = 1; i <= 7; i++) begin
      chk("to_no_ack", 32'(m0_wb_ack_o), 32'h0);
      chk("to_stb_on", 32'(s_wb_stb_o), 32'h1);
      step();
    end
    chk("to_ack", 32'(m0_wb_ack_o), 32'h1);
    chk("to_dat", 32'(m0_wb_dat_o), 32'hFF);
    chk("to_stb_forced", 32'(s_wb_stb_o), 32'h0);
    chk("to_err_before", 32'(timeout_err), 32'h0);
    err_clr = 1;  // coincident set and clear: set must win
    settle();
    step();
    m0_wb_cyc_i = 0; m0_wb_stb_i = 0;
    settle();
    chk("to_err_set", 32'(timeout_err), 32'h1);
    step();
    err_clr = 0;
    settle();
    chk("to_err_cleared", 32'(timeout_err), 32'h0);
    chk("to_release", 32'(gnt), 32'h0);

    // Ack coincident with the timeout cycle on m1
    m1_wb_cyc_i = 1; m1_wb_stb_i = 1;
    step();
    for (int i = 1; i <= 7; i++) step();
    s_wb_ack_i = 1; s_wb_dat_i = 8'h3C;
    settle();
    chk("race_ack", 32'(m1_wb_ack_o), 32'h1);
    chk("race_dat", 32'(m1_wb_dat_o), 32'h3C);
    chk("race_stb", 32'(s_wb_stb_o), 32'h1);
    step();
    s_wb_ack_i = 0; s_wb_dat_i = 0;
    m1_wb_cyc_i = 0; m1_wb_stb_i = 0;
    settle();
    chk("race_no_err", 32'(timeout_err), 32'h0);
    step();

    // Reset during an m1 write
    m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_we_i = 1; m1_wb_dat_i = 8'h11;
    step();
    chk("rst_mid_gnt_before", 32'(gnt), 32'h2);
    rst_n = 0; s_wb_ack_i = 1;
    settle();
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    chk("rst_mid_stb", 32'(s_wb_stb_o), 32'h0);
    chk("rst_mid_ack", 32'(m1_wb_ack_o), 32'h0);
    s_wb_ack_i = 0;
    step();
    rst_n = 1;
    step();
    chk("rst_resume_gnt", 32'(gnt), 32'h2);
    s_wb_ack_i = 1;
    settle();
    chk("rst_resume_ack", 32'(m1_wb_ack_o), 32'h1);
    step();
    s_wb_ack_i = 0;
    m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0;
    step();
    chk("final_idle", 32'(gnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
